// File: rtl/int_res_reader.sv
// Streams a vector of intermediate results out of word memory, pairing words
// into double-width elements when requested, through a 2-entry output FIFO.
module int_res_reader #(
    parameter int ADDR_W = 16,
    parameter int WORD_W = 15,
    parameter int LEN_W  = 7
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_W-1:0]     base_addr,
    input  logic [LEN_W-1:0]      len,
    input  logic                  width,
    output logic                  busy,
    output logic                  done,
    output logic                  mem_rd_en,
    output logic [ADDR_W-1:0]     mem_addr,
    input  logic [WORD_W-1:0]     mem_rd_data,
    output logic [2*WORD_W-1:0]   out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last
);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    localparam logic [LEN_W:0] LEFT_ONE = (LEN_W+1)'(1);

    state_t                r_state;
    state_t                w_next;

    logic                  r_wid;
    logic [ADDR_W-1:0]     r_addr;
    logic [ADDR_W-1:0]     r_last_addr;
    logic [LEN_W:0]        r_reads_left;
    logic                  r_half;
    logic                  r_rd_pend;
    logic                  r_rd_upper;
    logic                  r_rd_last;
    logic [WORD_W-1:0]     r_upper;
    logic [1:0]            r_inflight;
    logic                  r_done;

    logic [2*WORD_W-1:0]   r_fifo_data [2];
    logic [1:0]            r_fifo_last;
    logic                  r_wptr;
    logic                  r_rptr;
    logic [1:0]            r_count;

    logic                  w_pop;
    logic                  w_push;
    logic                  w_room;
    logic                  w_rd_en;
    logic                  w_new_elem;
    logic [2*WORD_W-1:0]   w_push_data;

    assign out_valid   = (r_count != 2'd0);
    assign out_data    = r_fifo_data[r_rptr];
    assign out_last    = out_valid && r_fifo_last[r_rptr];
    assign done        = r_done;
    assign mem_rd_en   = w_rd_en;
    assign mem_addr    = w_rd_en ? r_addr : r_last_addr;

    assign w_pop       = out_valid && out_ready;
    assign w_push      = r_rd_pend && (!r_wid || !r_rd_upper);
    assign w_new_elem  = w_rd_en && !r_half;
    assign w_push_data = r_wid ? {r_upper, mem_rd_data}
                               : {{WORD_W{mem_rd_data[WORD_W-1]}}, mem_rd_data};
    // Room counts elements already committed (queued or in flight) net of this cycle's pop.
    assign w_room      = (3'(r_count) + 3'(r_inflight)) < (3'd2 + 3'(w_pop));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start && (len != '0)) w_next = FETCH;
            FETCH:   if (w_rd_en && (r_reads_left == LEFT_ONE)) w_next = DRAIN;
            DRAIN:   if (w_pop && out_last) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // The second half of a double-width pair always follows its first read directly.
    always_comb begin
        busy    = (r_state != IDLE);
        w_rd_en = (r_state == FETCH) && (r_half || w_room);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wid        <= 1'b0;
            r_addr       <= '0;
            r_last_addr  <= '0;
            r_reads_left <= '0;
            r_half       <= 1'b0;
            r_rd_pend    <= 1'b0;
            r_rd_upper   <= 1'b0;
            r_rd_last    <= 1'b0;
            r_upper      <= '0;
            r_inflight   <= 2'd0;
            r_done       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_state == IDLE && start) begin
                r_done       <= (len == '0);
                r_wid        <= width;
                r_addr       <= base_addr;
                r_reads_left <= width ? {len, 1'b0} : {1'b0, len};
            end
            if (r_state == DRAIN && w_pop && out_last)
                r_done <= 1'b1;
            if (w_rd_en) begin
                r_addr       <= r_addr + ADDR_W'(1);
                r_last_addr  <= r_addr;
                r_reads_left <= r_reads_left - LEFT_ONE;
                r_half       <= r_wid && !r_half;
            end
            r_rd_pend  <= w_rd_en;
            r_rd_upper <= w_rd_en && r_wid && !r_half;
            r_rd_last  <= w_rd_en && (r_reads_left == LEFT_ONE);
            if (r_rd_pend && r_rd_upper)
                r_upper <= mem_rd_data;
            case ({w_new_elem, w_push})
                2'b10:   r_inflight <= r_inflight + 2'd1;
                2'b01:   r_inflight <= r_inflight - 2'd1;
                default: r_inflight <= r_inflight;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) r_fifo_data[i] <= '0;
            r_fifo_last <= 2'b00;
            r_wptr      <= 1'b0;
            r_rptr      <= 1'b0;
            r_count     <= 2'd0;
        end else begin
            if (w_push) begin
                r_fifo_data[r_wptr] <= w_push_data;
                r_fifo_last[r_wptr] <= r_rd_last;
                r_wptr              <= !r_wptr;
            end
            if (w_pop)
                r_rptr <= !r_rptr;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: doc/int_res_reader.md
INT_RES_READER -- requirements
Module: int_res_reader

Interface
REQ-001 Parameter ADDR_W, default 16, intermediate-result address width (covers 4 banks x 15872 words).
REQ-002 Parameter WORD_W, default 15, stored word width (single-width intermediate result).
REQ-003 Parameter LEN_W, default 7, vector length width (0..64).
REQ-004 clk  input  1  single clock; all logic rising-edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  one-cycle request; sampled only in IDLE.
REQ-007 base_addr  input  ADDR_W  first word address; sampled with start.
REQ-008 len  input  LEN_W  number of elements; sampled with start.
REQ-009 width  input  1  0 = SINGLE_WIDTH, 1 = DOUBLE_WIDTH; sampled with start.
REQ-010 busy  output  1  high while a transfer is in progress.
REQ-011 done  output  1  one-cycle pulse at transfer completion.
REQ-012 mem_rd_en  output  1  memory read strobe.
REQ-013 mem_addr  output  ADDR_W  memory read address.
REQ-014 mem_rd_data  input  WORD_W  read data, valid exactly 1 cycle after mem_rd_en.
REQ-015 out_data  output  2*WORD_W  signed element.
REQ-016 out_valid  output  1  element valid.
REQ-017 out_ready  input  1  downstream ready; transfer when out_valid && out_ready.
REQ-018 out_last  output  1  qualifies the final element of a transfer.

Function
REQ-019 FSM states SHALL be IDLE, FETCH, DRAIN; IDLE->FETCH on start with len>0; FETCH->DRAIN after last read issued; DRAIN->IDLE on last element handshake.
REQ-020 start with len=0 SHALL issue no reads, emit no elements, and pulse done in the following cycle.
REQ-021 start while busy SHALL be ignored; latched base_addr/len/width SHALL not change mid-transfer.
REQ-022 SINGLE_WIDTH: element k read from base_addr+k; out_data = word sign-extended to 2*WORD_W.
REQ-023 DOUBLE_WIDTH: element k read from base_addr+2k (upper half, bits [2*WORD_W-1:WORD_W]) then base_addr+2k+1 (lower half); halves read in consecutive read slots in that order.
REQ-024 Address arithmetic SHALL be modulo 2^ADDR_W; range checking is the caller's responsibility.
REQ-025 Elements SHALL be buffered in a 2-entry FIFO; a read (or double-width read pair's first read) SHALL issue only when FIFO occupancy + in-flight elements - pops this cycle < 2, so no returned data is ever dropped.
REQ-026 With out_ready held high, SINGLE_WIDTH throughput SHALL be 1 element/cycle; DOUBLE_WIDTH 1 element/2 cycles.
REQ-027 Latency: start in cycle 0 -> first mem_rd_en in cycle 1 -> out_valid in cycle 3 (SINGLE) or cycle 4 (DOUBLE).
REQ-028 out_valid SHALL stay high and out_data/out_last stable until handshake (no withdrawal).
REQ-029 out_last SHALL be high only with the len-th element.
REQ-030 done SHALL pulse the cycle after the out_last handshake; busy SHALL be high from the cycle after start until that cycle, low in the done cycle.
REQ-031 mem_rd_en SHALL never assert in IDLE or DRAIN; mem_addr SHALL hold its last value when mem_rd_en is low.

Reset
REQ-032 rst_n low SHALL immediately force IDLE, busy=0, done=0, mem_rd_en=0, mem_addr=0, out_valid=0, out_last=0, out_data=0, FIFO empty.
REQ-033 Reset mid-transfer SHALL abort; read data returning after reset release SHALL be discarded.
REQ-034 After reset release, the block SHALL accept start on the first rising edge.

Verification
REQ-035 SINGLE, base_addr=3840, len=64, out_ready=1, memory word(a)=a[14:0] -> 64 elements sign-extended, one per cycle from cycle 3, out_last on element 63, done one cycle later.
REQ-036 DOUBLE, base_addr=20000, len=4, words 0x4000,0x0001,... -> out_data[0]=0x20000001 (upper 0x4000, lower 0x0001), reads at 20000..20007, one element every 2 cycles.
REQ-037 SINGLE, len=16, out_ready toggled random 50% -> no lost/duplicated elements, ordering preserved, occupancy+in-flight never exceeds 2.
REQ-038 len=0 start -> zero mem_rd_en, zero out_valid, done pulse in cycle 1, busy never high.
REQ-039 base_addr=65534, len=4, SINGLE -> addresses 65534, 65535, 0, 1.
REQ-040 rst_n asserted after 5 of 32 elements -> all outputs zero same cycle; new start len=2 afterwards yields exactly 2 fresh elements and done.
